// File: rtl/window_generator_bin.sv
`default_nettype none
// ============================================================================
// Module      : window_generator_bin
// Description : Sliding window generator for a raster-order 1-bit pixel
//               stream. Buffers (window_width-1) image rows in shift-register
//               line buffers and emits one flattened window_width x
//               window_width binary window per accepted pixel, one clock after
//               the pixel is accepted.
//               Optional build macro: WINDOW_EDGE_MASK_EN - when defined,
//               out_ready is suppressed for windows that straddle a row
//               boundary (pixel column < window_width-1).
// Revision    : 1.0 - initial release
// ============================================================================
module window_generator_bin #(
  parameter int window_width  = 5,
  parameter int im_width      = 320,
  parameter int im_width_bits = 9
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_enable,
  input  logic                                   in_data,
  output logic                                   out_ready,
  output logic [window_width*window_width-1:0]   out_data
);

  localparam int c_NW       = window_width * window_width;
  localparam int c_ROW_BITS = $clog2(window_width);

  localparam logic [im_width_bits-1:0] c_COL_LAST        = im_width_bits'(im_width - 1);
  localparam logic [im_width_bits-1:0] c_COL_FIRST_VALID = im_width_bits'(window_width - 1);
  localparam logic [c_ROW_BITS-1:0]    c_ROW_LAST        = c_ROW_BITS'(window_width - 1);

  // Line buffers: buffer k holds the pixel that entered (k+1)*im_width pixels ago
  // in its MSB at the moment a new pixel is accepted.
  logic [im_width-1:0]      r_lb [window_width-1];
  logic [window_width-2:0]  w_lb_in;

  // Newest window column, index = window row (0 = oldest image row).
  logic [window_width-1:0]  w_col;

  logic [c_NW-1:0]          r_win;
  logic [c_NW-1:0]          w_win_nxt;

  logic [im_width_bits-1:0] r_col;
  logic [c_ROW_BITS-1:0]    r_row;
  logic                     r_ready;
  logic                     w_col_ok;
  logic                     w_valid;

  assign w_col[window_width-1] = in_data;

  generate
    for (genvar k = 0; k < window_width - 1; k++) begin : g_lb
      if (k == 0) begin : g_first
        assign w_lb_in[k] = in_data;
      end else begin : g_chain
        assign w_lb_in[k] = r_lb[k-1][im_width-1];
      end

      // Shift one pixel into the line buffer for every accepted pixel.
      always_ff @(posedge clk) begin
        if (in_enable) begin
          r_lb[k] <= {r_lb[k][im_width-2:0], w_lb_in[k]};
        end
      end

      // Deeper buffer -> older image row -> lower window row index.
      assign w_col[window_width-2-k] = r_lb[k][im_width-1];
    end
  endgenerate

  // Next window: every row shifts one column left, newest column enters at the right.
  generate
    for (genvar r = 0; r < window_width; r++) begin : g_row
      for (genvar c = 0; c < window_width - 1; c++) begin : g_col
        assign w_win_nxt[r*window_width+c] = r_win[r*window_width+c+1];
      end
      assign w_win_nxt[r*window_width+window_width-1] = w_col[r];
    end
  endgenerate

  assign w_col_ok = (r_col >= c_COL_FIRST_VALID);

`ifdef WINDOW_EDGE_MASK_EN
  // Only windows lying entirely inside one image row are flagged valid.
  assign w_valid = (r_row == c_ROW_LAST) && w_col_ok;
`else
  // Set once the row counter has saturated and a further row has begun, so
  // every later pixel (including column 0..window_width-2) is valid.
  logic r_row_past;

  // Track whether the stream has moved beyond the first full-window row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_past <= 1'b0;
    end else if (!in_enable) begin
      r_row_past <= 1'b0;
    end else if ((r_col == c_COL_LAST) && (r_row == c_ROW_LAST)) begin
      r_row_past <= 1'b1;
    end
  end

  assign w_valid = (r_row == c_ROW_LAST) && (w_col_ok || r_row_past);
`endif

  // Position counters, window register and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_ready <= 1'b0;
      r_win   <= '0;
    end else if (!in_enable) begin
      r_col   <= '0;
      r_row   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= w_valid;
      r_win   <= w_win_nxt;
      if (r_col == c_COL_LAST) begin
        r_col <= '0;
        if (r_row != c_ROW_LAST) begin
          r_row <= r_row + c_ROW_BITS'(1);
        end
      end else begin
        r_col <= r_col + im_width_bits'(1);
      end
    end
  end

  assign out_ready = r_ready;
  assign out_data  = r_win;

endmodule
`default_nettype wire

// File: tb/tb_window_generator_bin.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_generator_bin
// Description : Self-checking bench for window_generator_bin (3x3 window,
//               8-pixel rows). Reference model stores every accepted pixel
//               and builds each window directly from the image coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_generator_bin;

  localparam int W   = 3;
  localparam int IM  = 8;
  localparam int IMB = 3;
  localparam int NW  = W * W;

  logic          clk;
  logic          rst_n;
  logic          in_enable;
  logic          in_data;
  logic          out_ready;
  logic [NW-1:0] out_data;

  window_generator_bin #(
    .window_width  (W),
    .im_width      (IM),
    .im_width_bits (IMB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_enable (in_enable),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit            pix[$];
  int            cur_p;
  bit            have_last;
  logic [NW-1:0] last_data;

  typedef struct {
    bit            en;
    bit            din;
    bit            chk_rdy;
    bit            exp_rdy;
    bit            chk_dat;
    logic [NW-1:0] exp_dat;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_valid(input int p);
    bit v;
    v = (p >= (W - 1) * IM + (W - 1));
`ifdef WINDOW_EDGE_MASK_EN
    v = v && ((p % IM) >= (W - 1));
`endif
    return v;
  endfunction

  // Window for pixel p: row r, column c = pixel p - (W-1-r)*IM - (W-1-c).
  function automatic logic [NW-1:0] exp_win(input int p);
    logic [NW-1:0] w;
    w = '0;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        w[r*W+c] = pix[p - (W-1-r)*IM - (W-1-c)];
    return w;
  endfunction

  function automatic void model_reset();
    pix.delete();
    cur_p     = -1;
    have_last = 1'b1;
    last_data = '0;
  endfunction

  // One clock: drive at negedge, sample 1 time unit after posedge, compare to model.
  task automatic step(input bit en, input bit d);
    bit er;
    @(negedge clk);
    in_enable = en;
    in_data   = d;
    @(posedge clk);
    #1;
    if (en) begin
      pix.push_back(d);
      cur_p = pix.size() - 1;
      er = exp_valid(cur_p);
      chk("model_ready", {{(NW-1){1'b0}}, out_ready}, {{(NW-1){1'b0}}, er});
      if (er) begin
        last_data = exp_win(cur_p);
        chk("model_data", out_data, last_data);
      end
      have_last = er;
    end else begin
      pix.delete();
      cur_p = -1;
      chk("clear_ready", {{(NW-1){1'b0}}, out_ready}, '0);
      if (have_last) chk("hold_data", out_data, last_data);
    end
  endtask

  // 19 all-ones pixels from a cleared stream: first valid output is p=18.
  task automatic refill(input string name);
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 1'b1);
      if (i == 17) chk({name, "_p17_not_ready"}, {{(NW-1){1'b0}}, out_ready}, '0);
      if (i == 18) begin
        chk({name, "_p18_ready"}, {{(NW-1){1'b0}}, out_ready}, 9'h001);
        chk({name, "_p18_data"}, out_data, 9'h1FF);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    in_enable = 1'b1;
    in_data   = 1'b0;
    model_reset();

    // Asynchronous reset with in_enable high: outputs zero throughout.
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ready_async", {{(NW-1){1'b0}}, out_ready}, '0);
    chk("reset_data_async", out_data, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_data = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("reset_ready_hold", {{(NW-1){1'b0}}, out_ready}, '0);
      chk("reset_data_hold", out_data, '0);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    in_enable = 1'b0;

    // All-ones stream: first valid at p=18, then high every cycle to p=30.
    refill("ones");
    for (int i = 19; i <= 30; i++) begin
      step(1'b1, 1'b1);
`ifdef WINDOW_EDGE_MASK_EN
      if (i == 24 || i == 25) chk("mask_straddle_low", {{(NW-1){1'b0}}, out_ready}, '0);
      if (i == 26) chk("mask_p26_high", {{(NW-1){1'b0}}, out_ready}, 9'h001);
`else
      if (i == 24) chk("nomask_p24_high", {{(NW-1){1'b0}}, out_ready}, 9'h001);
`endif
    end

    // One-cycle disable after p=30, then a full refill.
    step(1'b0, 1'b0);
    chk("disable_ready_low", {{(NW-1){1'b0}}, out_ready}, '0);
    refill("reenable");

    // Asynchronous reset in the middle of a clock cycle.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_ready_async", {{(NW-1){1'b0}}, out_ready}, '0);
    chk("midreset_data_async", out_data, '0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    in_enable = 1'b0;
    refill("post_reset");

    // Table-driven: single 1 at image (row1,col1) = p9.
    for (int i = 0; i < 20; i++) begin
      tbl[i] = '{en: 1'b1, din: (i == 9), chk_rdy: 1'b1, exp_rdy: (i >= 18),
                 chk_dat: (i >= 18), exp_dat: '0};
    end
    tbl[18].exp_dat = 9'h010;
    tbl[19].exp_dat = 9'h008;
    tbl[20] = '{en: 1'b0, din: 1'b0, chk_rdy: 1'b1, exp_rdy: 1'b0, chk_dat: 1'b1, exp_dat: 9'h008};

    step(1'b0, 1'b0);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].en, tbl[i].din);
      if (tbl[i].chk_rdy) chk("tbl_ready", {{(NW-1){1'b0}}, out_ready}, {{(NW-1){1'b0}}, tbl[i].exp_rdy});
      if (tbl[i].chk_dat) chk("tbl_data", out_data, tbl[i].exp_dat);
    end

    // Randomized stream with occasional disables, checked against the model.
    for (int i = 0; i < 900; i++) begin
      step(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
